// File: rtl/ula_multiciclo_if.sv
// ula_multiciclo_if: start/busy/done handshake and operand/result bus
// between the control unit (master) and the multi-cycle ALU (slave).
interface ula_multiciclo_if #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
);
    logic             start;
    logic [CTL_W-1:0] ALUctl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUOut;
    logic             Zero;

    modport master (
        output start, ALUctl, A, B,
        input  busy, done, ALUOut, Zero
    );

    modport slave (
        input  start, ALUctl, A, B,
        output busy, done, ALUOut, Zero
    );
endinterface

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered ALU with iterative multiply; defining
// ULA_MULTICICLO_DIV_EN adds a restoring unsigned divide on opcode 11.
module ula_multiciclo #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    ula_multiciclo_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [CTL_W-1:0] OP_HLF = CTL_W'(1);
    localparam logic [CTL_W-1:0] OP_LFH = CTL_W'(2);
    localparam logic [CTL_W-1:0] OP_BNE = CTL_W'(3);
    localparam logic [CTL_W-1:0] OP_LW  = CTL_W'(4);
    localparam logic [CTL_W-1:0] OP_SW  = CTL_W'(5);
    localparam logic [CTL_W-1:0] OP_BEQ = CTL_W'(6);
    localparam logic [CTL_W-1:0] OP_CNT = CTL_W'(7);
    localparam logic [CTL_W-1:0] OP_SET = CTL_W'(8);
    localparam logic [CTL_W-1:0] OP_SUB = CTL_W'(9);
    localparam logic [CTL_W-1:0] OP_MUL = CTL_W'(10);
`ifdef ULA_MULTICICLO_DIV_EN
    localparam logic [CTL_W-1:0] OP_DIV = CTL_W'(11);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [WIDTH-1:0] r_a, w_a;
    logic [WIDTH-1:0] r_b, w_b;
    logic [WIDTH-1:0] r_acc, w_acc;
    logic [WIDTH-1:0] r_out, w_out;
    logic             r_zero, w_zero;
    logic             r_done, w_done;

    logic [WIDTH-1:0] w_sum, w_dif, w_res;
    logic             w_isbr, w_brz, w_zsc;

`ifdef ULA_MULTICICLO_DIV_EN
    logic [WIDTH:0] w_rem_sh, w_rem_dif;

    // r_a = divisor, r_b = dividend shifting out / quotient shifting in
    assign w_rem_sh  = {r_acc, r_b[WIDTH-1]};
    assign w_rem_dif = w_rem_sh - {1'b0, r_a};
`endif

    assign w_sum = bus.A + bus.B;
    assign w_dif = bus.A - bus.B;

    always_comb begin
        w_res  = '0;
        w_isbr = 1'b0;
        w_brz  = 1'b0;
        case (bus.ALUctl)
            OP_HLF: w_res = bus.A >> 1;
            OP_LFH: w_res = bus.A;
            OP_BNE: begin
                w_res  = w_dif;
                w_isbr = 1'b1;
                w_brz  = (bus.A != bus.B);
            end
            OP_LW, OP_SW, OP_CNT: w_res = w_sum;
            OP_BEQ: begin
                w_res  = w_dif;
                w_isbr = 1'b1;
                w_brz  = (bus.A == bus.B);
            end
            OP_SET: w_res = bus.B;
            OP_SUB: w_res = w_dif;
`ifdef ULA_MULTICICLO_DIV_EN
            OP_DIV: w_res = '1;
`endif
            default: w_res = '0;
        endcase
        w_zsc = w_isbr ? w_brz : (w_res == '0);
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_a     = r_a;
        w_b     = r_b;
        w_acc   = r_acc;
        w_out   = r_out;
        w_zero  = r_zero;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.ALUctl == OP_MUL) begin
                        w_a     = bus.A;
                        w_b     = bus.B;
                        w_acc   = '0;
                        w_cnt   = '0;
                        w_state = S_MUL;
`ifdef ULA_MULTICICLO_DIV_EN
                    end else if (bus.ALUctl == OP_DIV &&
                                 bus.B != '0) begin
                        w_a     = bus.B;
                        w_b     = bus.A;
                        w_acc   = '0;
                        w_cnt   = '0;
                        w_state = S_DIV;
`endif
                    end else begin
                        w_out  = w_res;
                        w_zero = w_zsc;
                        w_done = 1'b1;
                    end
                end
            end
            S_MUL: begin
                w_acc = r_acc + (r_b[0] ? r_a : '0);
                w_a   = r_a << 1;
                w_b   = r_b >> 1;
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_out   = w_acc;
                    w_zero  = (w_acc == '0);
                    w_done  = 1'b1;
                    w_cnt   = '0;
                    w_state = S_IDLE;
                end
            end
`ifdef ULA_MULTICICLO_DIV_EN
            S_DIV: begin
                if (!w_rem_dif[WIDTH]) begin
                    w_acc = w_rem_dif[WIDTH-1:0];
                    w_b   = {r_b[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc = w_rem_sh[WIDTH-1:0];
                    w_b   = {r_b[WIDTH-2:0], 1'b0};
                end
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_out   = w_b;
                    w_zero  = (w_b == '0);
                    w_done  = 1'b1;
                    w_cnt   = '0;
                    w_state = S_IDLE;
                end
            end
`endif
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_a     <= w_a;
            r_b     <= w_b;
            r_acc   <= w_acc;
            r_out   <= w_out;
            r_zero  <= w_zero;
            r_done  <= w_done;
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = r_done;
    assign bus.ALUOut = r_out;
    assign bus.Zero   = r_zero;
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed vectors for single-cycle ops plus
// hand-written multi-cycle, ignored-start and reset sequences.
module tb_ula_multiciclo;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ula_multiciclo_if #(.WIDTH(W), .CTL_W(4)) bus ();

    ula_multiciclo #(.WIDTH(W), .CTL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] last_out;
    logic        last_z;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge of the done cycle.
    task automatic multi(input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic ez,
                         input bit inject);
        bus.start  = 1'b1;
        bus.ALUctl = op;
        bus.A      = a;
        bus.B      = b;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            if (c <= W) begin
                check($sformatf("%s busy c%0d", nm, c), 32'(bus.busy), 1);
                check($sformatf("%s done c%0d", nm, c), 32'(bus.done), 0);
                check($sformatf("%s hold c%0d", nm, c), bus.ALUOut,
                      last_out);
            end else begin
                check({nm, " done"}, 32'(bus.done), 1);
                check({nm, " busy end"}, 32'(bus.busy), 0);
                check({nm, " out"}, bus.ALUOut, eo);
                check({nm, " zero"}, 32'(bus.Zero), 32'(ez));
            end
            if (c == 1) begin
                bus.start = 1'b0;
                bus.A     = $urandom;
                bus.B     = $urandom;
            end
            if (inject && c == 10) begin
                bus.start  = 1'b1;
                bus.ALUctl = 4'd7;
                bus.A      = 32'd5;
                bus.B      = 32'd3;
            end
            if (inject && c == 11) bus.start = 1'b0;
        end
        last_out = eo;
        last_z   = ez;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.ALUctl = '0;
        bus.A      = '0;
        bus.B      = '0;

        vecs.push_back('{4'd7,  32'd5,        32'd3,        32'd8,        1'b0});
        vecs.push_back('{4'd9,  32'd4,        32'd4,        32'd0,        1'b1});
        vecs.push_back('{4'd1,  32'd9,        32'd0,        32'd4,        1'b0});
        vecs.push_back('{4'd6,  32'h1234,     32'h1234,     32'd0,        1'b1});
        vecs.push_back('{4'd3,  32'h10,       32'h0F,       32'd1,        1'b1});
        vecs.push_back('{4'd6,  32'd1,        32'd2,        32'hFFFFFFFF, 1'b0});
        vecs.push_back('{4'd3,  32'd7,        32'd7,        32'd0,        1'b0});
        vecs.push_back('{4'd0,  32'd5,        32'd6,        32'd0,        1'b1});
        vecs.push_back('{4'd2,  32'hABCD,     32'd0,        32'hABCD,     1'b0});
        vecs.push_back('{4'd4,  32'hFFFFFFFF, 32'd2,        32'd1,        1'b0});
        vecs.push_back('{4'd5,  32'd100,      32'hFFFFFF9C, 32'd0,        1'b1});
        vecs.push_back('{4'd8,  32'd3,        32'h55,       32'h55,       1'b0});
        vecs.push_back('{4'd9,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0});
        vecs.push_back('{4'd1,  32'h80000001, 32'd0,        32'h40000000, 1'b0});
        vecs.push_back('{4'd12, 32'd1,        32'd1,        32'd0,        1'b1});
        vecs.push_back('{4'd15, 32'd9,        32'd9,        32'd0,        1'b1});
`ifdef ULA_MULTICICLO_DIV_EN
        vecs.push_back('{4'd11, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0});
`else
        vecs.push_back('{4'd11, 32'd100,      32'd7,        32'd0,        1'b1});
`endif

        repeat (2) @(negedge clk);
        check("reset out", bus.ALUOut, 0);
        check("reset zero", 32'(bus.Zero), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // start held high: one result per cycle, done stays high
        foreach (vecs[i]) begin
            bus.start  = 1'b1;
            bus.ALUctl = vecs[i].op;
            bus.A      = vecs[i].a;
            bus.B      = vecs[i].b;
            @(negedge clk);
            check($sformatf("vec%0d out", i), bus.ALUOut, vecs[i].out);
            check($sformatf("vec%0d zero", i), 32'(bus.Zero),
                  32'(vecs[i].z));
            check($sformatf("vec%0d done", i), 32'(bus.done), 1);
            check($sformatf("vec%0d busy", i), 32'(bus.busy), 0);
            last_out = vecs[i].out;
            last_z   = vecs[i].z;
        end
        bus.start = 1'b0;
        @(negedge clk);
        check("idle done", 32'(bus.done), 0);
        check("idle hold", bus.ALUOut, last_out);

        multi("mul16", 4'd10, 32'h00010000, 32'h00010000, 32'd0, 1'b1, 1'b0);
        multi("mul1000", 4'd10, 32'd1000, 32'd1000, 32'd1000000, 1'b0, 1'b1);

        // reset in the middle of a multiply
        bus.start  = 1'b1;
        bus.ALUctl = 4'd10;
        bus.A      = 32'd7;
        bus.B      = 32'd9;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        check("pre-rst busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst out", bus.ALUOut, 0);
        check("rst zero", 32'(bus.Zero), 0);
        check("rst busy", 32'(bus.busy), 0);
        check("rst done", 32'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge clk);
            check($sformatf("post-rst done c%0d", c), 32'(bus.done), 0);
        end
        check("post-rst out", bus.ALUOut, 0);
        last_out = 32'd0;
        last_z   = 1'b0;

        multi("mulff", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
`ifdef ULA_MULTICICLO_DIV_EN
        multi("div100", 4'd11, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
        multi("div7", 4'd11, 32'd7, 32'd9, 32'd0, 1'b1, 1'b0);
        multi("divff", 4'd11, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
`endif
        @(negedge clk);
        check("final done", 32'(bus.done), 0);
        check("final hold", bus.ALUOut, last_out);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
